// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked write arbiter that merges byte-stream requesters
// into one shared FIFO. A grant is held from the first byte to the last byte.
// If the granted requester stalls for TIMEOUT cycles, the grant is dropped and
// abort pulses for one cycle. The next search always starts one index past
// the requester that was served last.
module fifo_wr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 fifo_din,
   output logic                       fifo_wr_en,
   input  logic                       fifo_full,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       abort,
   output logic [15:0]                pkt_count
);

   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [7:0]      idle_q, idle_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            abort_d;
   logic [GW-1:0]   sel_idx;
   logic            sel_found;

   // Round-robin search: first valid requester at or after grant_q+1, wrapping.
   // Scanning from the far end lets the nearest candidate win the last write.
   always_comb begin
      int            idx;
      logic [GW-1:0] cand;
      sel_found = 1'b0;
      sel_idx   = grant_q;
      idx       = 0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx  = (int'(grant_q) + k) % NUM_REQ;
         cand = GW'(idx);
         if (req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // FSM next state, byte handshake toward requesters and FIFO, idle timeout.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      idle_d     = idle_q;
      cnt_d      = cnt_q;
      abort_d    = 1'b0;
      req_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = req_data[{grant_q, 3'b000} +: 8];
      case (state_q)
         IDLE: begin
            // Arbitration cycle: no byte moves, the winner owns the next cycle.
            if (sel_found) begin
               grant_d = sel_idx;
               state_d = BUSY;
               idle_d  = 8'd0;
            end
         end
         BUSY: begin
            req_ready[grant_q] = ~fifo_full;
            fifo_wr_en         = req_valid[grant_q] & ~fifo_full;
            if (fifo_wr_en) begin
               idle_d = 8'd0;
               if (req_last[grant_q]) begin
                  state_d = IDLE;
                  cnt_d   = cnt_q + 16'd1;
               end
            end else if (!fifo_full) begin
               // A full FIFO is backpressure, not requester silence, so only
               // cycles with the FIFO able to accept count toward the timeout.
               if (idle_q == 8'(TIMEOUT - 1)) begin
                  state_d = IDLE;
                  abort_d = 1'b1;
               end else begin
                  idle_d = idle_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, grant, idle counter, packet counter and abort pulse registers.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= IDLE;
         grant_q <= GW'(NUM_REQ - 1);
         idle_q  <= 8'd0;
         cnt_q   <= 16'd0;
         abort   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idle_q  <= idle_d;
         cnt_q   <= cnt_d;
         abort   <= abort_d;
      end
   end

   assign busy      = (state_q == BUSY);
   assign grant_id  = grant_q;
   assign pkt_count = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios followed by a randomized run,
// all checked every cycle against a transaction-level arbiter model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           srst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [7:0]     fifo_din;
   logic           fifo_wr_en;
   logic           fifo_full;
   logic           busy;
   logic [1:0]     grant_id;
   logic           abort;
   logic [15:0]    pkt_count;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .srst(srst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .fifo_din(fifo_din),
      .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .busy(busy),
      .grant_id(grant_id), .abort(abort), .pkt_count(pkt_count)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: owner of the FIFO (if any), last served index, stall length,
   // completed packets and a pending abort flag.
   bit         m_busy;
   bit         m_abort;
   logic [1:0] m_gid;
   int         m_idle;
   int         m_cnt;

   // Driver state: packet length and bytes already delivered per requester.
   int plen [N];
   int sent [N];

   // Observations of the DUT taken at each write strobe / abort pulse.
   int cyc_no = 0;
   int gq [$];
   int wq [$];
   int abort_seen = 0;
   int abort_cyc  = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_data[8*i +: 8] = 8'((i << 5) | (sent[i] & 31));
         req_last[i]        = (sent[i] == plen[i] - 1);
      end
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_abort = 0;
      m_gid   = 2'(N - 1);
      m_idle  = 0;
      m_cnt   = 0;
      for (int i = 0; i < N; i++) sent[i] = 0;
   endtask

   // One clock: check outputs against the model, then advance the model.
   task automatic cyc();
      logic [N-1:0] e_ready;
      bit           e_wr;
      bit           found;
      logic [1:0]   start;
      logic [1:0]   ci;
      drive();
      #1;
      e_ready = '0;
      e_wr    = 0;
      if (m_busy && !fifo_full) begin
         e_ready[m_gid] = 1'b1;
         e_wr           = req_valid[m_gid];
      end
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("abort", 32'(abort), 32'(m_abort));
      chk("pkt_count", 32'(pkt_count), 32'(m_cnt));
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
      if (e_wr) chk("fifo_din", 32'(fifo_din), 32'(req_data[{m_gid, 3'b000} +: 8]));
      if (fifo_wr_en === 1'b1) begin
         gq.push_back(int'(grant_id));
         wq.push_back(cyc_no);
      end
      if (abort === 1'b1) begin
         abort_seen++;
         abort_cyc = cyc_no;
      end
      @(posedge clk);
      if (srst) begin
         model_reset();
      end else begin
         m_abort = 0;
         if (!m_busy) begin
            found = 0;
            start = m_gid;
            for (int k = 1; k <= N; k++) begin
               ci = 2'((int'(start) + k) % N);
               if (!found && req_valid[ci]) begin
                  found  = 1;
                  m_gid  = ci;
                  m_busy = 1;
                  m_idle = 0;
               end
            end
         end else if (e_wr) begin
            m_idle = 0;
            if (req_last[m_gid]) begin
               m_busy       = 0;
               m_cnt        = (m_cnt + 1) % 65536;
               sent[m_gid]  = 0;
            end else begin
               sent[m_gid]++;
            end
         end else if (!fifo_full) begin
            m_idle++;
            if (m_idle == TO) begin
               m_busy      = 0;
               m_abort     = 1;
               sent[m_gid] = 0;
            end
         end
      end
      @(negedge clk);
      cyc_no++;
   endtask

   task automatic do_reset();
      srst = 1'b1;
      cyc();
      srst = 1'b0;
   endtask

   initial begin
      int guard;
      int pct;
      srst      = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      for (int i = 0; i < N; i++) plen[i] = 3;
      model_reset();
      @(posedge clk);
      @(negedge clk);

      // Reset state, held for two cycles.
      cyc();
      cyc();
      srst = 1'b0;

      // Requesters 1 and 2, three-byte packets: 1 first, then 2.
      gq.delete();
      req_valid = 4'b0110;
      guard = 0;
      while (m_cnt < 2 && guard < 30) begin cyc(); guard++; end
      req_valid = '0;
      cyc();
      chk("s1_pkts", 32'(pkt_count), 32'd2);
      chk("s1_nwr", 32'(gq.size()), 32'd6);
      for (int i = 0; i < 6 && i < gq.size(); i++)
         chk("s1_order", 32'(gq[i]), (i < 3) ? 32'd1 : 32'd2);

      // All requesters valid, one-byte packets: rotating order, 2-cycle gaps.
      do_reset();
      for (int i = 0; i < N; i++) plen[i] = 1;
      gq.delete();
      wq.delete();
      req_valid = 4'b1111;
      for (int c = 0; c < 10; c++) cyc();
      req_valid = '0;
      cyc();
      chk("s2_nwr", 32'(gq.size()), 32'd5);
      for (int i = 0; i < 5 && i < gq.size(); i++)
         chk("s2_order", 32'(gq[i]), 32'(i % N));
      for (int i = 1; i < 5 && i < wq.size(); i++)
         chk("s2_gap", 32'(wq[i] - wq[i-1]), 32'd2);

      // FIFO full for five cycles in the middle of requester 0's packet.
      do_reset();
      plen[0]    = 6;
      abort_seen = 0;
      req_valid  = 4'b0001;
      guard = 0;
      while (sent[0] < 2 && guard < 20) begin cyc(); guard++; end
      fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cyc();
         chk("s3_full_wr", 32'(fifo_wr_en), 32'd0);
         chk("s3_full_rdy", 32'(req_ready), 32'd0);
      end
      fifo_full = 1'b0;
      guard = 0;
      while (m_cnt < 1 && guard < 20) begin cyc(); guard++; end
      req_valid = '0;
      cyc();
      chk("s3_pkts", 32'(pkt_count), 32'd1);
      chk("s3_abort", 32'(abort_seen), 32'd0);

      // Requester 2 stalls after one byte: timeout abort, then search from 3.
      do_reset();
      plen[2]    = 4;
      abort_seen = 0;
      abort_cyc  = -1;
      wq.delete();
      req_valid  = 4'b0100;
      guard = 0;
      while (sent[2] < 1 && guard < 10) begin cyc(); guard++; end
      req_valid = '0;
      guard = 0;
      while (abort_seen == 0 && guard < 40) begin cyc(); guard++; end
      chk("s4_abort_seen", 32'(abort_seen), 32'd1);
      if (wq.size() > 0)
         chk("s4_abort_delay", 32'(abort_cyc - wq[wq.size()-1]), 32'd17);
      gq.delete();
      for (int i = 0; i < N; i++) plen[i] = 1;
      req_valid = 4'b1001;
      for (int c = 0; c < 4; c++) cyc();
      req_valid = '0;
      cyc();
      chk("s4_abort_once", 32'(abort_seen), 32'd1);
      chk("s4_pkts", 32'(pkt_count), 32'd2);
      if (gq.size() > 0) chk("s4_next_grant", 32'(gq[0]), 32'd3);
      else chk("s4_next_grant_seen", 32'd0, 32'(gq.size() + 1));

      // Reset in the middle of requester 3's packet, then a normal packet.
      do_reset();
      plen[3]    = 5;
      abort_seen = 0;
      req_valid  = 4'b1000;
      guard = 0;
      while (sent[3] < 2 && guard < 10) begin cyc(); guard++; end
      srst = 1'b1;
      cyc();
      srst = 1'b0;
      #1;
      chk("s5_busy", 32'(busy), 32'd0);
      chk("s5_grant", 32'(grant_id), 32'd3);
      chk("s5_pkts", 32'(pkt_count), 32'd0);
      chk("s5_rdy", 32'(req_ready), 32'd0);
      chk("s5_wr", 32'(fifo_wr_en), 32'd0);
      gq.delete();
      guard = 0;
      while (m_cnt < 1 && guard < 20) begin cyc(); guard++; end
      req_valid = '0;
      cyc();
      chk("s5_pkts_after", 32'(pkt_count), 32'd1);
      chk("s5_abort", 32'(abort_seen), 32'd0);
      chk("s5_nwr", 32'(gq.size()), 32'd5);

      // Randomized traffic, backpressure, stalls and occasional resets.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         pct = ((c / 400) % 2 == 1) ? 10 : 80;
         srst      = ($urandom_range(0, 199) == 0);
         fifo_full = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom_range(0, 99) < pct);
            if (sent[i] == 0 && !(m_busy && m_gid == 2'(i))) plen[i] = $urandom_range(1, 4);
         end
         cyc();
      end
      srst = 1'b0;
      req_valid = '0;
      fifo_full = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of byte-stream requesters (legal 2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, max idle cycles mid-packet before abort (legal 1..255).
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-004 The block SHALL have port srst, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ, per-requester byte valid.
REQ-006 The block SHALL have port req_data, input, 8*NUM_REQ, per-requester byte; requester i on bits [8i+7:8i].
REQ-007 The block SHALL have port req_last, input, NUM_REQ, marks final byte of requester's packet.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ, byte accepted when valid&ready in same cycle.
REQ-009 The block SHALL have port fifo_din, output, 8, byte to shared FIFO.
REQ-010 The block SHALL have port fifo_wr_en, output, 1, FIFO write strobe.
REQ-011 The block SHALL have port fifo_full, input, 1, FIFO full flag.
REQ-012 The block SHALL have port busy, output, 1, high while a packet is granted.
REQ-013 The block SHALL have port grant_id, output, clog2(NUM_REQ), index of current/last granted requester.
REQ-014 The block SHALL have port abort, output, 1, one-cycle pulse on timeout release.
REQ-015 The block SHALL have port pkt_count, output, 16, completed packets (wraps 0xFFFF->0).

Function
REQ-016 FSM SHALL have states IDLE and BUSY; busy = (state==BUSY).
REQ-017 In IDLE, any req_valid high SHALL select the first valid index searching from (grant_id+1) mod NUM_REQ upward, load grant_id, enter BUSY next cycle; no byte accepted in the arbitration cycle.
REQ-018 In IDLE, req_ready SHALL be all-zero and fifo_wr_en SHALL be 0.
REQ-019 In BUSY, req_ready[grant_id] SHALL equal !fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-020 In BUSY, fifo_wr_en SHALL equal req_valid[grant_id] & !fifo_full, and fifo_din SHALL equal req_data of grant_id (combinational, zero added latency).
REQ-021 When fifo_full is high, no byte SHALL be written or acknowledged; packet stays locked.
REQ-022 An accepted byte with req_last[grant_id] high SHALL return FSM to IDLE next cycle and increment pkt_count by 1.
REQ-023 Grant SHALL stay locked to grant_id until last byte or abort; other requesters' valid SHALL be ignored meanwhile.
REQ-024 8-bit idle counter SHALL reset to 0 on entering BUSY and on each accepted byte, increment each BUSY cycle with req_valid[grant_id] low and fifo_full low, and hold while fifo_full is high.
REQ-025 Idle counter reaching TIMEOUT SHALL force IDLE next cycle, pulse abort for exactly one cycle, leave pkt_count unchanged.
REQ-026 After release (last or abort), grant_id SHALL hold so the next search starts after it (round-robin fairness).
REQ-027 A sole active requester SHALL be re-granted after one IDLE cycle (2-cycle gap minimum between packets).
REQ-028 Wrap: search from NUM_REQ-1 SHALL continue at index 0.

Reset
REQ-029 With srst high at posedge clk, state SHALL become IDLE, busy 0, abort 0, pkt_count 0, idle counter 0, grant_id NUM_REQ-1 (first grant favours requester 0).
REQ-030 srst mid-packet SHALL drop the grant without abort pulse; req_ready and fifo_wr_en SHALL be 0 in the cycle following reset.
REQ-031 srst SHALL take priority over every other event in the same cycle.

Verification
REQ-032 Reset, then req_valid=4'b0110, 3-byte packets each -> requester 1 granted first (grant_id=1), bytes in order on fifo_din, then requester 2; pkt_count=2.
REQ-033 All four requesters continuously valid, 1-byte packets -> grant order 0,1,2,3,0; each fifo_wr_en pulse separated by one IDLE cycle.
REQ-034 fifo_full high 5 cycles mid-packet of requester 0 -> fifo_wr_en=0, req_ready=0 for those cycles, no abort, packet completes after full drops.
REQ-035 Requester 2 drops valid after 1 byte, TIMEOUT=16 -> abort pulses once, 16 idle cycles after last accepted byte, pkt_count unchanged, next grant searches from 3.
REQ-036 srst asserted during requester 3 packet -> next cycle busy=0, grant_id=3, pkt_count=0; subsequent request from 3 alone granted normally.
REQ-037 pkt_count preloaded by 65535 completions -> next completion wraps to 0.
